// File: rtl/coh_bus_arbiter.sv
// Round-robin arbiter for the shared coherence bus: grants one requester at a time,
// revokes unused grants, broadcasts the owner's message and flags protocol/hold errors.
module coh_bus_arbiter #(
    parameter int N           = 4,
    parameter int MSG_W       = 64,
    parameter int GNT_TIMEOUT = 4,
    parameter int MAX_HOLD    = 64
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N-1:0]       i_req,
    input  logic [N-1:0]       i_busy,
    input  logic [N*MSG_W-1:0] i_tx,
    output logic [N-1:0]       o_gnt,
    output logic [MSG_W-1:0]   o_bus_msg,
    output logic               o_bus_valid,
    output logic               o_hold_err,
    output logic               o_proto_err
);

    localparam int OW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [N-1:0] ONE_HOT0 = N'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_OWNED = 2'd2
    } state_t;

    state_t        r_state;
    logic [OW-1:0] r_owner;
    logic [OW-1:0] r_ptr;
    logic [3:0]    r_wait_cnt;
    logic [HW-1:0] r_hold_cnt;
    logic [N-1:0]  r_gnt;
    logic          r_hold_err;
    logic          r_proto_err;

    state_t        w_state_nxt;
    logic [OW-1:0] w_owner_nxt;
    logic [OW-1:0] w_ptr_nxt;
    logic [3:0]    w_wait_nxt;
    logic [HW-1:0] w_hold_nxt;
    logic [OW-1:0] w_pick;
    logic          w_found;
    logic          w_owner_busy;
    logic          w_busy_viol;
    logic [N-1:0]  w_owner_mask;
    logic [OW-1:0] w_owner_inc;

    // First requester at or after ptr, wrapping modulo N.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && i_req[(int'(r_ptr) + i) % N]) begin
                w_found = 1'b1;
                w_pick  = OW'((int'(r_ptr) + i) % N);
            end
        end
    end

    always_comb begin
        w_owner_mask = ONE_HOT0 << r_owner;
        w_owner_busy = |(i_busy & w_owner_mask);
        w_busy_viol  = (r_state == S_IDLE) ? (|i_busy) : (|(i_busy & ~w_owner_mask));
        w_owner_inc  = (int'(r_owner) == N - 1) ? '0 : r_owner + 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_wait_nxt  = r_wait_cnt;
        w_hold_nxt  = r_hold_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_GRANT;
                    w_owner_nxt = w_pick;
                    w_wait_nxt  = '0;
                end
            end
            S_GRANT: begin
                if (w_owner_busy) begin
                    w_state_nxt = S_OWNED;
                    w_hold_nxt  = '0;
                end else if (r_wait_cnt + 4'd1 == 4'(GNT_TIMEOUT)) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = w_owner_inc;
                end else begin
                    w_wait_nxt = r_wait_cnt + 4'd1;
                end
            end
            S_OWNED: begin
                // Overlong holds are only reported; the owner keeps the bus.
                if (!w_owner_busy) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = w_owner_inc;
                end else if (r_hold_cnt != HW'(MAX_HOLD)) begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_owner     <= '0;
            r_ptr       <= '0;
            r_wait_cnt  <= '0;
            r_hold_cnt  <= '0;
            r_gnt       <= '0;
            r_hold_err  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_ptr       <= w_ptr_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_gnt       <= (w_state_nxt != S_IDLE) ? (ONE_HOT0 << w_owner_nxt) : '0;
            r_hold_err  <= r_hold_err | (w_hold_nxt == HW'(MAX_HOLD));
            r_proto_err <= r_proto_err | w_busy_viol;
        end
    end

    assign o_gnt       = r_gnt;
    assign o_bus_valid = (r_state == S_OWNED) && w_owner_busy;
    assign o_bus_msg   = (r_state == S_OWNED) ? i_tx[int'(r_owner)*MSG_W +: MSG_W] : '0;
    assign o_hold_err  = r_hold_err;
    assign o_proto_err = r_proto_err;

endmodule

// File: tb/tb_coh_bus_arbiter.sv
// Directed bench for coh_bus_arbiter: cycle table for handoff/fairness, hand sequences
// for timeout, error flags and reset.
module tb_coh_bus_arbiter;

    localparam int N = 4;
    localparam int MSG_W = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N-1:0]     busy;
    logic [N*MSG_W-1:0] tx;
    logic [N-1:0]     gnt;
    logic [MSG_W-1:0] bus_msg;
    logic             bus_valid;
    logic             hold_err;
    logic             proto_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] sl [0:3];

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  busy;
        logic [3:0]  gnt;
        logic        valid;
        logic [63:0] msg;
    } vec_t;
    vec_t tbl[$];

    coh_bus_arbiter #(.N(N), .MSG_W(MSG_W), .GNT_TIMEOUT(4), .MAX_HOLD(64)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_busy(busy), .i_tx(tx),
        .o_gnt(gnt), .o_bus_msg(bus_msg), .o_bus_valid(bus_valid),
        .o_hold_err(hold_err), .o_proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic [3:0] b, input logic [3:0] g,
                       input logic v, input logic [63:0] m);
        vec_t e;
        e.req = r; e.busy = b; e.gnt = g; e.valid = v; e.msg = m;
        tbl.push_back(e);
    endtask

    task automatic cyc(input logic [3:0] r, input logic [3:0] b);
        @(negedge clk);
        req = r; busy = b;
        #1;
    endtask

    initial begin
        int cnt_gnt;
        int cnt_valid;
        logic [3:0] g;

        sl[0] = 64'hA0A0_0000_0000_0011;
        sl[1] = 64'h0000_0000_0000_00AB;
        sl[2] = 64'hC2C2_0000_0000_0022;
        sl[3] = 64'hD3D3_0000_0000_0033;
        tx = {sl[3], sl[2], sl[1], sl[0]};

        // Single handoff 1 -> 3
        add(4'b1010, 4'b0000, 4'b0000, 1'b0, 64'h0);
        add(4'b1000, 4'b0010, 4'b0010, 1'b0, 64'h0);
        add(4'b1000, 4'b0010, 4'b0010, 1'b1, sl[1]);
        add(4'b1000, 4'b0010, 4'b0010, 1'b1, sl[1]);
        add(4'b1000, 4'b0010, 4'b0010, 1'b1, sl[1]);
        add(4'b1000, 4'b0000, 4'b0010, 1'b0, sl[1]);
        add(4'b1000, 4'b0000, 4'b0000, 1'b0, 64'h0);
        add(4'b0000, 4'b1000, 4'b1000, 1'b0, 64'h0);
        add(4'b0000, 4'b1000, 4'b1000, 1'b1, sl[3]);
        add(4'b0000, 4'b0000, 4'b1000, 1'b0, sl[3]);
        add(4'b0000, 4'b0000, 4'b0000, 1'b0, 64'h0);
        // Fairness: all requesting, order 0,1,2,3 then back to 0
        for (int k = 0; k < 4; k++) begin
            g = 4'b0001 << k;
            add(4'b1111, 4'b0000, 4'b0000, 1'b0, 64'h0);
            add(4'b1111, g,       g,       1'b0, 64'h0);
            add(4'b1111, g,       g,       1'b1, sl[k]);
            add(4'b1111, g,       g,       1'b1, sl[k]);
            add(4'b1111, 4'b0000, g,       1'b0, sl[k]);
        end
        add(4'b1111, 4'b0000, 4'b0000, 1'b0, 64'h0);
        add(4'b0000, 4'b0001, 4'b0001, 1'b0, 64'h0);
        add(4'b0000, 4'b0000, 4'b0001, 1'b0, sl[0]);
        add(4'b0000, 4'b0000, 4'b0000, 1'b0, 64'h0);

        rst = 1'b1; req = '0; busy = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset gnt", 64'(gnt), 64'h0);
        check("reset valid", 64'(bus_valid), 64'h0);
        check("reset msg", bus_msg, 64'h0);
        check("reset hold_err", 64'(hold_err), 64'h0);
        check("reset proto_err", 64'(proto_err), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            cyc(tbl[i].req, tbl[i].busy);
            check($sformatf("vec%0d gnt", i), 64'(gnt), 64'(tbl[i].gnt));
            check($sformatf("vec%0d valid", i), 64'(bus_valid), 64'(tbl[i].valid));
            check($sformatf("vec%0d msg", i), bus_msg, tbl[i].msg);
            check($sformatf("vec%0d proto_err", i), 64'(proto_err), 64'h0);
        end

        // Timeout: grant to 2 never used; ptr ends at 3
        cyc(4'b0100, 4'b0000);
        cnt_gnt = 0; cnt_valid = 0;
        for (int c = 0; c < 10; c++) begin
            cyc(4'b0000, 4'b0000);
            if (gnt == 4'b0100) cnt_gnt++;
            if (bus_valid) cnt_valid++;
        end
        check("timeout gnt cycles", 64'(cnt_gnt), 64'd4);
        check("timeout valid cycles", 64'(cnt_valid), 64'd0);
        cyc(4'b1101, 4'b0000);
        cyc(4'b0000, 4'b1000);
        check("ptr after timeout", 64'(gnt), 64'(4'b1000));
        cyc(4'b0000, 4'b0000);
        cyc(4'b0000, 4'b0000);

        // Foreign busy while 1 owns, then long hold
        cyc(4'b0010, 4'b0000);
        cyc(4'b0000, 4'b0010);
        check("err grant", 64'(gnt), 64'(4'b0010));
        cyc(4'b0000, 4'b1010);
        check("err msg owner", bus_msg, sl[1]);
        check("err valid", 64'(bus_valid), 64'h1);
        check("proto before edge", 64'(proto_err), 64'h0);
        cyc(4'b0000, 4'b0010);
        check("proto_err set", 64'(proto_err), 64'h1);
        check("proto msg", bus_msg, sl[1]);
        for (int c = 0; c < 70; c++) begin
            cyc(4'b0000, 4'b0010);
            if (c == 5) check("hold_err early", 64'(hold_err), 64'h0);
        end
        check("hold_err set", 64'(hold_err), 64'h1);
        check("hold gnt kept", 64'(gnt), 64'(4'b0010));
        check("hold valid kept", 64'(bus_valid), 64'h1);
        cyc(4'b0000, 4'b0000);
        cyc(4'b0000, 4'b0000);

        // Reset while 2 owns the bus
        cyc(4'b0100, 4'b0000);
        cyc(4'b0000, 4'b0100);
        cyc(4'b0000, 4'b0100);
        check("pre-reset owner valid", 64'(bus_valid), 64'h1);
        #2 rst = 1'b1;
        #1;
        check("rst gnt", 64'(gnt), 64'h0);
        check("rst valid", 64'(bus_valid), 64'h0);
        check("rst msg", bus_msg, 64'h0);
        check("rst hold_err", 64'(hold_err), 64'h0);
        check("rst proto_err", 64'(proto_err), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc(4'b1111, 4'b0000);
        cyc(4'b0000, 4'b0000);
        check("post-reset gnt", 64'(gnt), 64'(4'b0001));

        // Busy while idle is a protocol error
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cyc(4'b0000, 4'b0100);
        cyc(4'b0000, 4'b0000);
        check("idle busy proto_err", 64'(proto_err), 64'h1);
        check("idle busy gnt", 64'(gnt), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
